// File: rtl/power_state_reg.sv
// Registered power/run/moving state of the car: long-press power-on qualification,
// immediate and stall power-off, and idle auto power-off.
module power_state_reg #(
    parameter int unsigned LONG_PRESS_CYC = 100_000_000,
    parameter int unsigned IDLE_CYC       = 1_000_000_000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_on,
    input  logic       power_off,
    input  logic       activity,
    input  logic       manual_power,
    input  logic [1:0] next_state,
    input  logic [3:0] next_moving_state,
    output logic       power,
    output logic [1:0] state,
    output logic [3:0] moving_state,
    output logic       power_pending
);

    typedef enum logic [1:0] {
        S_OFF    = 2'b00,
        S_ARMING = 2'b01,
        S_ON     = 2'b10
    } fsm_e;

    localparam logic [CNT_W-1:0] LONG_C    = CNT_W'(LONG_PRESS_CYC);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             pon_meta_q, pon_s_q, poff_meta_q, poff_s_q;
    fsm_e             fsm_q, fsm_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             power_q, power_d;
    logic             pending_q, pending_d;
    logic [1:0]       state_q, state_d;
    logic [3:0]       moving_q, moving_d;
    logic             idle_c;

    // Two-flop synchronizers for the raw buttons
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pon_meta_q  <= 1'b0;
            pon_s_q     <= 1'b0;
            poff_meta_q <= 1'b0;
            poff_s_q    <= 1'b0;
        end else begin
            pon_meta_q  <= power_on;
            pon_s_q     <= pon_meta_q;
            poff_meta_q <= power_off;
            poff_s_q    <= poff_meta_q;
        end
    end

    assign idle_c = (state_q == 2'b00) && !activity;

    // Next-state logic; outputs default to the powered-off values
    always_comb begin
        fsm_d       = fsm_q;
        press_cnt_d = press_cnt_q;
        idle_cnt_d  = '0;
        state_d     = 2'b00;
        moving_d    = 4'b0000;
        case (fsm_q)
            S_OFF: begin
                press_cnt_d = '0;
                if (!poff_s_q && pon_s_q) begin
                    if (LONG_PRESS_CYC == 1) begin
                        fsm_d = S_ON;
                    end else begin
                        fsm_d       = S_ARMING;
                        press_cnt_d = CNT_ONE;
                    end
                end
            end
            S_ARMING: begin
                if (poff_s_q || !pon_s_q) begin
                    fsm_d       = S_OFF;
                    press_cnt_d = '0;
                end else if (press_cnt_q == LONG_C) begin
                    fsm_d       = S_ON;
                    press_cnt_d = '0;
                end else if (press_cnt_q != CNT_MAX) begin
                    press_cnt_d = press_cnt_q + CNT_ONE;
                end
            end
            S_ON: begin
                press_cnt_d = '0;
                if (poff_s_q || !manual_power || (idle_c && idle_cnt_q == IDLE_LAST)) begin
                    fsm_d = S_OFF;
                end else begin
                    state_d  = (next_state == 2'b11) ? 2'b00 : next_state;
                    moving_d = next_moving_state;
                    if (idle_c) begin
                        idle_cnt_d = (idle_cnt_q == CNT_MAX) ? idle_cnt_q : idle_cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                fsm_d       = S_OFF;
                press_cnt_d = '0;
            end
        endcase
        power_d   = (fsm_d == S_ON);
        pending_d = (fsm_d == S_ARMING);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q       <= S_OFF;
            press_cnt_q <= '0;
            idle_cnt_q  <= '0;
            power_q     <= 1'b0;
            pending_q   <= 1'b0;
            state_q     <= 2'b00;
            moving_q    <= 4'b0000;
        end else begin
            fsm_q       <= fsm_d;
            press_cnt_q <= press_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            power_q     <= power_d;
            pending_q   <= pending_d;
            state_q     <= state_d;
            moving_q    <= moving_d;
        end
    end

    assign power         = power_q;
    assign state         = state_q;
    assign moving_state  = moving_q;
    assign power_pending = pending_q;

endmodule

// File: tb/tb_power_state_reg.sv
// Scoreboard bench for power_state_reg: stimulus queues expected outputs per
// falling-edge slot, a monitor compares them as the slots come up.
module tb_power_state_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       power_on, power_off, activity, manual_power;
    logic [1:0] next_state;
    logic [3:0] next_moving_state;
    logic       power;
    logic [1:0] state;
    logic [3:0] moving_state;
    logic       power_pending;

    power_state_reg #(
        .LONG_PRESS_CYC(4),
        .IDLE_CYC      (8),
        .CNT_W         (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .power_on         (power_on),
        .power_off        (power_off),
        .activity         (activity),
        .manual_power     (manual_power),
        .next_state       (next_state),
        .next_moving_state(next_moving_state),
        .power            (power),
        .state            (state),
        .moving_state     (moving_state),
        .power_pending    (power_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        logic [7:0]  val;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int unsigned n_cnt  = 0;
    int          checks = 0;
    int          errors = 0;

    // Expected {power, state, moving_state, power_pending} after k more rising edges
    task automatic expect_at(input int k, input logic p, input logic [1:0] st,
                             input logic [3:0] mv, input logic pend, input string tag);
        exp_t e;
        int   pos;
        e.idx = n_cnt + k - 1;
        e.val = {p, st, mv, pend};
        e.tag = tag;
        pos   = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].idx > e.idx) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation whose slot is this falling edge
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].idx <= n_cnt) begin
            cur = sb.pop_front();
            checks++;
            if (cur.idx < n_cnt) begin
                errors++;
                $display("FAIL %s: slot %0d missed (now %0d)", cur.tag, cur.idx, n_cnt);
            end else if ({power, state, moving_state, power_pending} !== cur.val) begin
                errors++;
                $display("FAIL %s: got pwr=%b st=%b mv=%b pend=%b, want pwr=%b st=%b mv=%b pend=%b",
                         cur.tag, power, state, moving_state, power_pending,
                         cur.val[7], cur.val[6:5], cur.val[4:1], cur.val[0]);
            end
        end
        n_cnt++;
    end

    initial begin
        rst = 1'b0; power_on = 1'b0; power_off = 1'b0; activity = 1'b1;
        manual_power = 1'b1; next_state = 2'b01; next_moving_state = 4'b0001;
        step(1);
        expect_at(1, 0, 2'b00, 4'b0000, 0, "reset");
        step(1);
        rst = 1'b1;

        // Long press to power on
        power_on = 1'b1;
        expect_at(2, 0, 2'b00, 4'b0000, 0, "t1_pend_low");
        expect_at(3, 0, 2'b00, 4'b0000, 1, "t1_pend");
        expect_at(6, 0, 2'b00, 4'b0000, 1, "t1_pre_on");
        expect_at(7, 1, 2'b00, 4'b0000, 0, "t1_on");
        step(7);
        expect_at(1, 1, 2'b01, 4'b0001, 0, "t1_load");
        step(1);
        power_on = 1'b0;

        // Move, then power-off pulse
        next_state = 2'b10; next_moving_state = 4'b0100;
        expect_at(1, 1, 2'b10, 4'b0100, 0, "t3_move");
        step(1);
        power_off = 1'b1;
        expect_at(2, 1, 2'b10, 4'b0100, 0, "t3_off_hold");
        expect_at(3, 0, 2'b00, 4'b0000, 0, "t3_off");
        step(1);
        power_off = 1'b0;
        step(2);

        // Short press aborts
        power_on = 1'b1;
        expect_at(3, 0, 2'b00, 4'b0000, 1, "t2_pend");
        expect_at(5, 0, 2'b00, 4'b0000, 1, "t2_pend_last");
        expect_at(6, 0, 2'b00, 4'b0000, 0, "t2_abort");
        expect_at(10, 0, 2'b00, 4'b0000, 0, "t2_no_on");
        step(3);
        power_on = 1'b0;
        step(7);

        // power_off wins over power_on in OFF, then release power_off
        power_on = 1'b1; power_off = 1'b1;
        expect_at(3, 0, 2'b00, 4'b0000, 0, "t4_both");
        expect_at(8, 0, 2'b00, 4'b0000, 0, "t4_both_late");
        step(8);
        power_off = 1'b0;
        expect_at(3, 0, 2'b00, 4'b0000, 1, "t4_arm");
        expect_at(7, 1, 2'b00, 4'b0000, 0, "t4_on");
        step(7);
        power_on = 1'b0; next_state = 2'b01; next_moving_state = 4'b0001;
        expect_at(1, 1, 2'b01, 4'b0001, 0, "t4_run");
        step(1);
        manual_power = 1'b0;
        expect_at(1, 0, 2'b00, 4'b0000, 0, "t4_stall");
        step(1);
        manual_power = 1'b1;

        // Idle auto power-off
        power_on = 1'b1; next_state = 2'b00; next_moving_state = 4'b0000;
        expect_at(7, 1, 2'b00, 4'b0000, 0, "t5_on");
        step(7);
        power_on = 1'b0; activity = 1'b0;
        expect_at(7, 1, 2'b00, 4'b0000, 0, "t5_idle_hold");
        expect_at(8, 0, 2'b00, 4'b0000, 0, "t5_idle_off");
        step(8);

        // Activity pulse at the 5th edge restarts the idle count
        power_on = 1'b1; activity = 1'b1;
        expect_at(7, 1, 2'b00, 4'b0000, 0, "t5b_on");
        step(7);
        power_on = 1'b0; activity = 1'b0;
        expect_at(8, 1, 2'b00, 4'b0000, 0, "t5_restart_hold");
        expect_at(12, 1, 2'b00, 4'b0000, 0, "t5_pre");
        expect_at(13, 0, 2'b00, 4'b0000, 0, "t5_restart_off");
        step(4);
        activity = 1'b1;
        step(1);
        activity = 1'b0;
        step(8);

        // Asynchronous reset during ARMING
        power_on = 1'b1;
        expect_at(4, 0, 2'b00, 4'b0000, 1, "t6_arming");
        step(4);
        @(posedge clk);
        #1 rst = 1'b0;
        expect_at(1, 0, 2'b00, 4'b0000, 0, "t6_rst_arm");
        step(1);
        rst = 1'b1;
        expect_at(6, 0, 2'b00, 4'b0000, 1, "t6_re_pre");
        expect_at(7, 1, 2'b00, 4'b0000, 0, "t6_re_on");
        step(7);

        // Asynchronous reset while ON
        power_on = 1'b0; activity = 1'b1; next_state = 2'b01; next_moving_state = 4'b0010;
        expect_at(1, 1, 2'b01, 4'b0010, 0, "t6_run");
        step(1);
        @(posedge clk);
        #1 rst = 1'b0;
        expect_at(1, 0, 2'b00, 4'b0000, 0, "t6_rst_on");
        step(2);
        rst = 1'b1;
        expect_at(5, 0, 2'b00, 4'b0000, 0, "t6_post");
        step(5);

        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
